// File: rtl/pgm_sched.sv
// Packet-generator run control: owns bypass/start/finish flags, counts sent packets, software regs on control chain.
// Latency 1 cycle on control path; backpressure: ready passes straight through, beats move only on wr & ready.
module pgm_sched #(
    parameter logic [7:0] LMID   = 8'd63,
    parameter int         WDOG_W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] cin_sched_data,
    input  logic         cin_sched_data_wr,
    output logic         cout_sched_ready,
    output logic [133:0] cout_sched_data,
    output logic         cout_sched_data_wr,
    input  logic         cin_sched_ready,
    input  logic         pgm_store_done,
    input  logic         pkt_sent,
    input  logic         in_rd_alf,
    output logic         pgm_bypass_flag,
    output logic         pgm_sent_start_flag,
    output logic         pgm_sent_finish_flag,
    output logic         sched_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [1:0]        ctrl;
    logic [31:0]       pkt_total;
    logic [31:0]       sent_cnt;
    logic [WDOG_W-1:0] wdog_lim;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              err;
    logic              start_q;
    logic              finish_q;

    logic        beat_acc;
    logic        is_ctl;
    logic        is_wr;
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rd_val;

    assign beat_acc = cin_sched_data_wr & cin_sched_ready;
    assign is_ctl   = beat_acc && (cin_sched_data[133:132] == 2'b01) && (cin_sched_data[103:96] == LMID);
    assign is_wr    = is_ctl && (cin_sched_data[126:124] == 3'b010);
    assign is_rd    = is_ctl && (cin_sched_data[126:124] == 3'b001);
    assign addr     = cin_sched_data[95:64];
    assign wdat     = cin_sched_data[31:0];

    always_comb begin
        rd_val = 32'hffff_ffff;
        case (addr)
            32'd0: rd_val = {30'd0, ctrl};
            32'd1: rd_val = pkt_total;
            32'd2: rd_val = sent_cnt;
            32'd3: rd_val = {28'd0, err, state};
            32'd4: rd_val = 32'(wdog_lim);
            default: rd_val = 32'hffff_ffff;
        endcase
    end

    assign cout_sched_ready = cin_sched_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_sched_data_wr <= 1'b0;
            cout_sched_data    <= '0;
        end else begin
            cout_sched_data_wr <= beat_acc;
            cout_sched_data    <= is_rd ? {cin_sched_data[133:128], 4'b1011, cin_sched_data[123:32], rd_val}
                                        : cin_sched_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= 2'd0;
            pkt_total <= 32'd0;
            wdog_lim  <= '1;
        end else if (is_wr) begin
            case (addr)
                32'd0: ctrl      <= wdat[1:0];
                32'd1: pkt_total <= wdat;
                32'd4: wdog_lim  <= wdat[WDOG_W-1:0];
                default: ;
            endcase
        end
    end

    logic [31:0] cnt_nxt;
    logic        near_end;
    logic        last_tail;
    logic        wdog_hit;

    assign cnt_nxt   = sent_cnt + {31'd0, pkt_sent};
    assign near_end  = (pkt_total != 32'd0) && (cnt_nxt >= pkt_total - 32'd1);
    // >= rather than == so a total rewritten below the running count still ends on the next tail
    assign last_tail = pkt_sent && (pkt_total != 32'd0) && (cnt_nxt >= pkt_total);
    assign wdog_hit  = !pkt_sent && (wdog_cnt == wdog_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sent_cnt <= 32'd0;
            wdog_cnt <= '0;
            err      <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctrl[0] && pgm_store_done && !ctrl[1]) begin
                        sent_cnt <= 32'd0;
                        err      <= 1'b0;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!in_rd_alf) begin
                        start_q  <= 1'b1;
                        wdog_cnt <= '0;
                        finish_q <= (pkt_total == 32'd1);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sent_cnt <= cnt_nxt;
                    wdog_cnt <= pkt_sent ? '0 : wdog_cnt + 1'b1;
                    if (last_tail) begin
                        finish_q <= 1'b1;
                        state    <= S_DONE;
                    end else if (wdog_hit) begin
                        err      <= 1'b1;
                        finish_q <= 1'b1;
                        state    <= S_DONE;
                    end else if (!ctrl[0]) begin
                        finish_q <= 1'b1;
                        state    <= S_DRAIN;
                    end else begin
                        finish_q <= near_end;
                    end
                end
                S_DRAIN: begin
                    finish_q <= 1'b1;
                    sent_cnt <= cnt_nxt;
                    wdog_cnt <= pkt_sent ? '0 : wdog_cnt + 1'b1;
                    if (pkt_sent) begin
                        state <= S_DONE;
                    end else if (wdog_hit) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!ctrl[0]) begin
                        finish_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pgm_bypass_flag      = (state == S_IDLE) && ctrl[1];
    assign pgm_sent_start_flag  = start_q;
    assign pgm_sent_finish_flag = finish_q;
    assign sched_busy           = (state == S_ARM) || (state == S_RUN) || (state == S_DRAIN);

endmodule
